// File: rtl/clk_en_seq.sv
// Always-on 32 kHz sequencer for the CRGU gated clocks: efuse load, reset release,
// then afe/slot/data/timer enables brought up one step apart and torn down in reverse.
module clk_en_seq #(
    parameter int CNT_W    = 8,
    parameter int EFUSE_TO = 200
) (
    input  logic             clk_32k,
    input  logic             rst_32k,
    input  logic             rg_top_start,
    input  logic [CNT_W-1:0] rg_step_dly,
    input  logic             efuse_done,
    output logic             efuse_req,
    output logic             efuse_clk_en,
    output logic             afe_clk_en,
    output logic             slot_clk_en,
    output logic             data_clk_en,
    output logic             timer_clk_en,
    output logic             shut_rstn,
    output logic             seq_run,
    output logic             seq_err,
    output logic [2:0]       seq_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EFUSE  = 3'd1,
        S_PWR_UP = 3'd2,
        S_RUN    = 3'd3,
        S_PWR_DN = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(EFUSE_TO - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Thermometer code {timer, data, slot, afe}: shifting left brings up the next
    // clock, shifting right drops the highest one, so only one bit moves per edge.
    logic [3:0]       en_q, en_d;
    logic             efuse_q, efuse_d;
    logic             rstn_q, rstn_d;
    logic             run_q, run_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] step_dly;
    logic             step_hit;

    assign step_dly = (rg_step_dly == '0) ? ONE : rg_step_dly;
    assign step_hit = (cnt_q == ONE);

    always_ff @(posedge clk_32k or posedge rst_32k) begin
        if (rst_32k) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= '0;
            efuse_q <= 1'b0;
            rstn_q  <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            efuse_q <= efuse_d;
            rstn_q  <= rstn_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        efuse_d = efuse_q;
        rstn_d  = rstn_q;
        run_d   = run_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (rg_top_start) begin
                    state_d = S_EFUSE;
                    efuse_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_EFUSE: begin
                cnt_d = cnt_q + ONE;
                if (!rg_top_start) begin
                    efuse_d = 1'b0;
                    state_d = S_IDLE;
                end else if (efuse_done) begin
                    efuse_d = 1'b0;
                    rstn_d  = 1'b1;
                    cnt_d   = step_dly;
                    state_d = S_PWR_UP;
                end else if (cnt_q == TO_LAST) begin
                    efuse_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_PWR_UP: begin
                cnt_d = cnt_q - ONE;
                if (!rg_top_start) begin
                    if (en_q == '0) begin
                        rstn_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        en_d    = en_q >> 1;
                        cnt_d   = step_dly;
                        state_d = S_PWR_DN;
                    end
                end else if (step_hit) begin
                    en_d  = {en_q[2:0], 1'b1};
                    cnt_d = step_dly;
                    if (en_q[2]) begin
                        run_d   = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!rg_top_start) begin
                    en_d    = en_q >> 1;
                    run_d   = 1'b0;
                    cnt_d   = step_dly;
                    state_d = S_PWR_DN;
                end
            end
            S_PWR_DN: begin
                cnt_d = cnt_q - ONE;
                if (step_hit) begin
                    cnt_d = step_dly;
                    if (en_q == '0) begin
                        rstn_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        en_d = en_q >> 1;
                    end
                end
            end
            S_ERR: begin
                if (!rg_top_start) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = '0;
                efuse_d = 1'b0;
                rstn_d  = 1'b0;
                run_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign efuse_req    = efuse_q;
    assign efuse_clk_en = efuse_q;
    assign afe_clk_en   = en_q[0];
    assign slot_clk_en  = en_q[1];
    assign data_clk_en  = en_q[2];
    assign timer_clk_en = en_q[3];
    assign shut_rstn    = rstn_q;
    assign seq_run      = run_q;
    assign seq_err      = err_q;
    assign seq_state    = state_q;

endmodule
